// File: rtl/mips_pkg.sv
// Shared MIPS core types for the multiply unit.
// Holds the multiply FSM state encoding, the iteration count and the product type.
package mips_pkg;

  localparam int MULT_DATA_WIDTH = 32;
  localparam int MULT_CYCLES     = MULT_DATA_WIDTH;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_CALC = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_e;

  typedef logic [2*MULT_DATA_WIDTH-1:0] mult_product_t;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Pipeline-side bundle of the multiply/HI-LO unit.
// The EX stage and hazard control are the master; the unit is the slave.
interface mult_hilo_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  start;
  logic                  is_signed;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  flush;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  hilo_read;
  logic                  busy;
  logic                  done;
  logic                  stall;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b, flush, hi_we, lo_we, wdata, hilo_read,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b, flush, hi_we, lo_we, wdata, hilo_read,
    output busy, done, stall, hi, lo
  );

endinterface

// File: rtl/mult_hilo_ctrl_shift_add_dp.sv
// Radix-2 shift-add datapath: works on magnitudes, one multiplier bit per step,
// and presents the sign-corrected full-width product of the step in progress.
module mult_shift_add_dp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    is_signed,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic [PROD_WIDTH-1:0] acc;
  logic [PROD_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic                  neg_res;

  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;
  logic [PROD_WIDTH-1:0] addend;
  logic [PROD_WIDTH-1:0] acc_next;

  // The most negative operand negates to itself, which read unsigned is its exact magnitude.
  assign a_neg = is_signed & a[DATA_WIDTH-1];
  assign b_neg = is_signed & b[DATA_WIDTH-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  assign addend   = mplier[0] ? mcand : '0;
  assign acc_next = acc + addend;
  assign product  = neg_res ? -acc_next : acc_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc_next;
    end
  end

  // NOTE: operand registers carry no reset; load always writes them before a step reads them.
  always_ff @(posedge clk) begin
    if (load) begin
      mcand   <= {{DATA_WIDTH{1'b0}}, a_abs};
      mplier  <= b_abs;
      neg_res <= a_neg ^ b_neg;
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Iterative MULT/MULTU unit owning the architectural HI/LO registers.
// Serves MTHI/MTLO in IDLE and raises a stall request while a product is in flight.
module mult_hilo_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = MULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  mult_hilo_ctrl_if.slave bus
);

  mult_state_e           state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;

  logic                    load;
  logic                    step;
  logic                    last_iter;
  logic [2*DATA_WIDTH-1:0] product;

  assign load      = (state == MULT_IDLE) & bus.start & ~bus.flush;
  assign step      = (state == MULT_CALC) & ~bus.flush;
  assign last_iter = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  mult_shift_add_dp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .is_signed (bus.is_signed),
    .a         (bus.a),
    .b         (bus.b),
    .product   (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MULT_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state)
        MULT_IDLE: begin
          if (load) begin
            state <= MULT_CALC;
            cnt   <= '0;
          end else if (!bus.start) begin
            // A start, even a flushed one, owns the cycle and drops HI/LO writes.
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        MULT_CALC: begin
          if (bus.flush) begin
            state <= MULT_IDLE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (last_iter) begin
              {hi_q, lo_q} <= product;
              state        <= MULT_DONE;
            end
          end
        end
        MULT_DONE: state <= MULT_IDLE;
        default:   state <= MULT_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != MULT_IDLE);
  assign bus.done  = (state == MULT_DONE);
  // HI/LO are already committed in DONE, so a reader there may proceed.
  assign bus.stall = bus.busy & ~bus.done &
                     (bus.start | bus.hilo_read | bus.hi_we | bus.lo_we);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
